// File: rtl/flot_rec_pkg.sv
// Shared definitions for the reciprocal-unit scheduler: float format presets,
// unit latency per preset, and the tag layout carried alongside each operand.
package flot_rec_pkg;

    localparam int FP16_WIDTH   = 16;
    localparam int FP16_EXP     = 5;
    localparam int FP16_MAT     = 10;
    localparam int FP16_REC_LAT = 2;

    localparam int FP24_WIDTH   = 24;
    localparam int FP24_EXP     = 8;
    localparam int FP24_MAT     = 15;
    localparam int FP24_REC_LAT = 3;

    localparam int FP32_WIDTH   = 32;
    localparam int FP32_EXP     = 8;
    localparam int FP32_MAT     = 23;
    localparam int FP32_REC_LAT = 3;

    // Wide enough for the largest supported requester count (8).
    localparam int TAG_ID_MAX_W = 3;

    typedef struct packed {
        logic                    v;
        logic [TAG_ID_MAX_W-1:0] id;
    } rec_tag_t;

    localparam rec_tag_t TAG_IDLE = '{v: 1'b0, id: '0};

    function automatic int wrap_inc(input int x, input int n);
        return (x + 1 >= n) ? 0 : x + 1;
    endfunction

endpackage

// File: rtl/flot_rec_sched_rr_arbiter.sv
// Round-robin priority picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            any
);

    logic [N-1:0] rot;
    int           sel;
    int           idx;

    always_comb begin
        rot      = N'({req, req} >> ptr);
        sel      = 0;
        idx      = 0;
        any      = 1'b0;
        grant_id = '0;
        grant    = '0;
        // Descending scan so the lowest rotated position wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sel = i;
                any = 1'b1;
            end
        end
        idx = int'(ptr) + sel;
        if (idx >= N) idx = idx - N;
        grant_id = ID_W'(idx);
        any      = any & en;
        if (any) grant = N'(1) << grant_id;
    end

endmodule

// File: rtl/flot_rec_sched.sv
// Shares one pipelined reciprocal unit among NUM_REQ requesters; a tag pipe
// matching the unit latency routes each result back to its owner.
module flot_rec_sched
    import flot_rec_pkg::*;
#(
    parameter int WIDTH     = FP32_WIDTH,
    parameter int WIDTH_exp = FP32_EXP,
    parameter int WIDTH_mat = FP32_MAT,
    parameter int NUM_REQ   = 4,
    parameter int REC_LAT   = FP32_REC_LAT,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]      req_op,
    input  logic [NUM_REQ-1:0]            req_exce,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [WIDTH-1:0]              rsp_result,
    output logic                          rsp_exce,
    output logic [WIDTH-1:0]              rec_OP,
    output logic                          rec_exce_in,
    output logic                          rec_CE,
    input  logic [WIDTH-1:0]              rec_result,
    input  logic                          rec_exce_out,
    output logic [$clog2(REC_LAT+1)-1:0]  inflight
);

    localparam int CNT_W = $clog2(REC_LAT + 1);

    if (WIDTH_exp + WIDTH_mat + 1 != WIDTH || NUM_REQ < 2 || NUM_REQ > 8 || REC_LAT < 1)
    begin : g_param_chk
        $error("flot_rec_sched: unsupported parameter combination");
    end

    rec_tag_t        tag_q [REC_LAT];
    rec_tag_t        tag_d [REC_LAT];
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;

    logic            stall;
    logic            rsp_fire;
    logic            accept;
    logic [ID_W-1:0] grant_id;

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = tag_q[REC_LAT-1].v && (tag_q[REC_LAT-1].id == TAG_ID_MAX_W'(i));
        end
    end

    // A bubble at the head never stalls; only an unconsumed valid result does.
    assign rsp_fire   = |(rsp_valid & rsp_ready);
    assign stall      = tag_q[REC_LAT-1].v & ~rsp_fire;
    assign rec_CE     = ~stall;
    assign rsp_result = rec_result;
    assign rsp_exce   = rec_exce_out;
    assign inflight   = inflight_q;

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .req      (req_valid),
        .ptr      (rr_ptr_q),
        .en       (~stall),
        .grant    (req_ready),
        .grant_id (grant_id),
        .any      (accept)
    );

    always_comb begin
        rec_OP      = '0;
        rec_exce_in = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                rec_OP      = req_op[i*WIDTH +: WIDTH];
                rec_exce_in = req_exce[i];
            end
        end
    end

    always_comb begin
        for (int n = 0; n < REC_LAT; n++) tag_d[n] = tag_q[n];
        if (rec_CE) begin
            tag_d[0] = '{v: accept, id: TAG_ID_MAX_W'(grant_id)};
            for (int n = 1; n < REC_LAT; n++) tag_d[n] = tag_q[n-1];
        end

        rr_ptr_d = rr_ptr_q;
        if (accept) rr_ptr_d = ID_W'(wrap_inc(int'(grant_id), NUM_REQ));

        inflight_d = inflight_q;
        case ({accept, rsp_fire})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int n = 0; n < REC_LAT; n++) tag_q[n] <= TAG_IDLE;
            rr_ptr_q   <= '0;
            inflight_q <= '0;
        end else begin
            for (int n = 0; n < REC_LAT; n++) tag_q[n] <= tag_d[n];
            rr_ptr_q   <= rr_ptr_d;
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: tb/tb_flot_rec_sched.sv
// Directed bench for flot_rec_sched with a behavioural 3-stage reciprocal unit.
module tb_flot_rec_sched;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int LAT = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_op;
    logic [N-1:0]   req_exce;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [W-1:0]   rsp_result;
    logic           rsp_exce;
    logic [W-1:0]   rec_OP;
    logic           rec_exce_in;
    logic           rec_CE;
    logic [W-1:0]   rec_result;
    logic           rec_exce_out;
    logic [1:0]     inflight;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    flot_rec_sched #(
        .WIDTH(W), .WIDTH_exp(8), .WIDTH_mat(23), .NUM_REQ(N), .REC_LAT(LAT), .ID_W(2)
    ) dut (
        .CLK(clk), .RST(rst),
        .req_valid(req_valid), .req_op(req_op), .req_exce(req_exce), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_exce(rsp_exce),
        .rec_OP(rec_OP), .rec_exce_in(rec_exce_in), .rec_CE(rec_CE),
        .rec_result(rec_result), .rec_exce_out(rec_exce_out), .inflight(inflight)
    );

    function automatic logic [31:0] recip(input logic [31:0] x);
        case (x)
            32'h3F800000: return 32'h3F800000;
            32'h40000000: return 32'h3F000000;
            32'h3FE00000: return 32'h3F124925;
            32'h40800000: return 32'h3E800000;
            32'h41E00000: return 32'h3D124925;
            default:      return ~x;
        endcase
    endfunction

    // Behavioural unit: LAT registers, frozen when CE is low.
    logic [W-1:0] u_res [LAT] = '{default: '0};
    logic         u_ex  [LAT] = '{default: 1'b0};

    always @(posedge clk) begin
        if (rec_CE) begin
            u_res[0] <= recip(rec_OP);
            u_ex[0]  <= rec_exce_in;
            for (int n = 1; n < LAT; n++) begin
                u_res[n] <= u_res[n-1];
                u_ex[n]  <= u_ex[n-1];
            end
        end
    end

    assign rec_result   = u_res[LAT-1];
    assign rec_exce_out = u_ex[LAT-1];

    typedef struct {
        logic [3:0]  v;
        logic [3:0]  g;
        logic [3:0]  rv;
        logic [31:0] res;
        logic [1:0]  inf;
    } vec_t;

    vec_t        vq[$];
    logic [31:0] ops [N];

    task automatic add(input logic [3:0] v, input logic [3:0] g, input logic [3:0] rv,
                       input logic [31:0] res, input logic [1:0] inf);
        vec_t t;
        t.v = v; t.g = g; t.rv = rv; t.res = res; t.inf = inf;
        vq.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ops();
        ops[0] = 32'h3F800000;
        ops[1] = 32'h40000000;
        ops[2] = 32'h3FE00000;
        ops[3] = 32'h40800000;
        req_op = {ops[3], ops[2], ops[1], ops[0]};
    endtask

    initial begin
        logic [31:0] exp_op;
        req_valid = '0;
        req_exce  = '0;
        rsp_ready = '0;
        load_ops();

        #12 rst = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_ce",        32'(rec_CE),    1);
        chk("rst_op",        rec_OP,         0);
        chk("rst_inflight",  32'(inflight),  0);
        tick();

        // single request, fairness 3/0, then full rotation and drain
        add(4'b0100, 4'b0100, 4'b0000, 32'h0,        2'd0);
        add(4'b0000, 4'b0000, 4'b0000, 32'h0,        2'd1);
        add(4'b0000, 4'b0000, 4'b0000, 32'h0,        2'd1);
        add(4'b0000, 4'b0000, 4'b0100, 32'h3F124925, 2'd1);
        add(4'b0000, 4'b0000, 4'b0000, 32'h0,        2'd0);
        add(4'b1001, 4'b1000, 4'b0000, 32'h0,        2'd0);
        add(4'b1001, 4'b0001, 4'b0000, 32'h0,        2'd1);
        add(4'b1001, 4'b1000, 4'b0000, 32'h0,        2'd2);
        add(4'b1001, 4'b0001, 4'b1000, 32'h3E800000, 2'd3);
        add(4'b1111, 4'b0010, 4'b0001, 32'h3F800000, 2'd3);
        add(4'b1111, 4'b0100, 4'b1000, 32'h3E800000, 2'd3);
        add(4'b1111, 4'b1000, 4'b0001, 32'h3F800000, 2'd3);
        add(4'b1111, 4'b0001, 4'b0010, 32'h3F000000, 2'd3);
        add(4'b1111, 4'b0010, 4'b0100, 32'h3F124925, 2'd3);
        add(4'b0000, 4'b0000, 4'b1000, 32'h3E800000, 2'd3);
        add(4'b0000, 4'b0000, 4'b0001, 32'h3F800000, 2'd2);
        add(4'b0000, 4'b0000, 4'b0010, 32'h3F000000, 2'd1);
        add(4'b0000, 4'b0000, 4'b0000, 32'h0,        2'd0);

        foreach (vq[k]) begin
            req_valid = vq[k].v;
            rsp_ready = 4'b1111;
            #1;
            exp_op = '0;
            for (int i = 0; i < N; i++) if (vq[k].g[i]) exp_op = ops[i];
            chk($sformatf("v%0d_req_ready", k), 32'(req_ready), 32'(vq[k].g));
            chk($sformatf("v%0d_rec_op", k),    rec_OP,         exp_op);
            chk($sformatf("v%0d_rsp_valid", k), 32'(rsp_valid), 32'(vq[k].rv));
            chk($sformatf("v%0d_ce", k),        32'(rec_CE),    1);
            chk($sformatf("v%0d_inflight", k),  32'(inflight),  32'(vq[k].inf));
            if (vq[k].rv != 4'b0000) begin
                chk($sformatf("v%0d_result", k), rsp_result,      vq[k].res);
                chk($sformatf("v%0d_exce", k),   32'(rsp_exce),   0);
            end
            tick();
        end

        // backpressure on requester 1 (1/28)
        req_op[1*W +: W] = 32'h41E00000;
        req_op[0*W +: W] = 32'h40000000;
        req_valid = 4'b0010;
        rsp_ready = 4'b1101;
        #1 chk("bp_accept", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        req_valid = 4'b0001;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk($sformatf("bp_ce_%0d", s),       32'(rec_CE),    0);
            chk($sformatf("bp_ready_%0d", s),    32'(req_ready), 0);
            chk($sformatf("bp_rsp_valid_%0d", s), 32'(rsp_valid), 32'b0010);
            chk($sformatf("bp_result_%0d", s),   rsp_result,     32'h3D124925);
            chk($sformatf("bp_inflight_%0d", s), 32'(inflight),  1);
            tick();
        end
        rsp_ready = 4'b1111;
        #1;
        chk("rel_ce",        32'(rec_CE),    1);
        chk("rel_rsp_valid", 32'(rsp_valid), 32'b0010);
        chk("rel_result",    rsp_result,     32'h3D124925);
        chk("rel_grant",     32'(req_ready), 32'b0001);
        chk("rel_op",        rec_OP,         32'h40000000);
        tick();
        req_valid = 4'b0000;
        #1;
        chk("rel_no_dup",   32'(rsp_valid), 0);
        chk("rel_inflight", 32'(inflight),  1);
        tick();
        #1 chk("rel_gap", 32'(rsp_valid), 0);
        tick();
        #1;
        chk("rel_r0_valid",  32'(rsp_valid), 32'b0001);
        chk("rel_r0_result", rsp_result,     32'h3F000000);
        tick();
        #1 chk("rel_drained", 32'(inflight), 0);
        load_ops();

        // exception flag rides with exactly its own operand
        req_valid = 4'b1000;
        req_exce  = 4'b1000;
        #1;
        chk("ex_grant_a", 32'(req_ready),   32'b1000);
        chk("ex_in_a",    32'(rec_exce_in), 1);
        tick();
        req_exce = 4'b0000;
        #1;
        chk("ex_grant_b", 32'(req_ready),   32'b1000);
        chk("ex_in_b",    32'(rec_exce_in), 0);
        tick();
        req_valid = 4'b0000;
        tick();
        #1;
        chk("ex_rsp_a_valid", 32'(rsp_valid), 32'b1000);
        chk("ex_rsp_a_exce",  32'(rsp_exce),  1);
        chk("ex_rsp_a_res",   rsp_result,     32'h3E800000);
        tick();
        #1;
        chk("ex_rsp_b_valid", 32'(rsp_valid), 32'b1000);
        chk("ex_rsp_b_exce",  32'(rsp_exce),  0);
        tick();
        #1 chk("ex_idle", 32'(rsp_valid), 0);
        tick();

        // reset with operands in flight
        req_valid = 4'b0111;
        #1 chk("rf_grant0", 32'(req_ready), 32'b0001);
        tick();
        #1 chk("rf_grant1", 32'(req_ready), 32'b0010);
        tick();
        #1;
        chk("rf_grant2",   32'(req_ready), 32'b0100);
        chk("rf_inflight", 32'(inflight),  2);
        @(posedge clk);
        req_valid = 4'b0000;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rf_inflight_clr", 32'(inflight),  0);
        chk("rf_rsp_clr",      32'(rsp_valid), 0);
        for (int s = 0; s < 5; s++) begin
            tick();
            #1 chk($sformatf("rf_no_rsp_%0d", s), 32'(rsp_valid), 0);
        end
        req_valid = 4'b1001;
        #1;
        chk("rf_ptr_zero", 32'(req_ready), 32'b0001);
        chk("rf_op",       rec_OP,         32'h3F800000);
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        #1;
        chk("rf_next_valid",  32'(rsp_valid), 32'b0001);
        chk("rf_next_result", rsp_result,     32'h3F800000);
        tick();
        #1;
        chk("rf_next_done",  32'(rsp_valid), 0);
        chk("rf_final_infl", 32'(inflight),  0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
